// File: rtl/usb_pkg.sv
// Shared USB definitions: ULPI transmit FSM states, TX CMD prefix and the PID
// values the link and its bench refer to.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_STP,
    ST_ABORT
  } tx_state_t;

  localparam logic [3:0] ULPI_TXCMD_PREFIX = 4'h4;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;

  // First byte on the ULPI pins: a TX CMD carrying the PID nibble, or the raw PID.
  function automatic logic [7:0] tx_first_byte(input logic [7:0] pid, input logic txcmd_en);
    return txcmd_en ? {ULPI_TXCMD_PREFIX, pid[3:0]} : pid;
  endfunction

endpackage

// File: rtl/ulpi_tx_link.sv
// Link-side ULPI transmitter: UTMI byte stream in, TX CMD / NXT-paced data / STP
// out, with a clean abort when the PHY takes the bus by raising DIR.
module ulpi_tx_link
  import usb_pkg::*;
#(
  parameter logic TXCMD_EN = 1'b1
) (
  input  logic       ulpi_clk60_i,
  input  logic       ulpi_rst_i,
  input  logic [7:0] utmi_data_i,
  input  logic       utmi_txvalid_i,
  output logic       utmi_txready_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic [7:0] ulpi_data_in_o,
  output logic       ulpi_data_oe_o,
  output logic       ulpi_stp_o,
  output logic       tx_abort_o,
  output logic       tx_busy_o
);

  tx_state_t state;
  logic      dir_q;
  logic      bus_free;

  // The bus needs one turnaround cycle after DIR falls before the link drives it.
  assign bus_free       = !ulpi_dir_i && !dir_q;
  assign ulpi_data_oe_o = bus_free;
  assign tx_busy_o      = (state != ST_IDLE);

  // Handshake: a byte on utmi_data_i transfers on a clock edge where
  // utmi_txvalid_i and utmi_txready_o are both high; ready never waits on valid
  // falling, and a held byte may not change until it is taken.
  always_comb begin
    utmi_txready_o = 1'b0;
    case (state)
      ST_IDLE:          utmi_txready_o = utmi_txvalid_i && bus_free;
      ST_CMD, ST_DATA:  utmi_txready_o = utmi_txvalid_i && ulpi_nxt_i && !ulpi_dir_i;
      ST_ABORT:         utmi_txready_o = utmi_txvalid_i;
      default:          utmi_txready_o = 1'b0;
    endcase
  end

  always_ff @(posedge ulpi_clk60_i or posedge ulpi_rst_i) begin
    if (ulpi_rst_i) begin
      state          <= ST_IDLE;
      ulpi_data_in_o <= 8'h00;
      ulpi_stp_o     <= 1'b0;
      tx_abort_o     <= 1'b0;
      dir_q          <= 1'b1;
    end else begin
      dir_q      <= ulpi_dir_i;
      ulpi_stp_o <= 1'b0;
      tx_abort_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          ulpi_data_in_o <= 8'h00;
          if (utmi_txvalid_i && bus_free) begin
            ulpi_data_in_o <= tx_first_byte(utmi_data_i, TXCMD_EN);
            state          <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA: begin
          // CMD/DATA are only entered with the bus free, so DIR high here is a rising edge.
          if (ulpi_dir_i) begin
            tx_abort_o     <= 1'b1;
            ulpi_data_in_o <= 8'h00;
            state          <= ST_ABORT;
          end else if (ulpi_nxt_i) begin
            if (utmi_txvalid_i) begin
              ulpi_data_in_o <= utmi_data_i;
              state          <= ST_DATA;
            end else begin
              ulpi_data_in_o <= 8'h00;
              ulpi_stp_o     <= 1'b1;
              state          <= ST_STP;
            end
          end
        end
        ST_STP: begin
          ulpi_data_in_o <= 8'h00;
          state          <= ST_IDLE;
        end
        ST_ABORT: begin
          ulpi_data_in_o <= 8'h00;
          // Leave as soon as DIR is low; IDLE then waits out the turnaround cycle,
          // so a new TX CMD can reach the pins two clocks after DIR falls.
          if (!ulpi_dir_i && !utmi_txvalid_i) state <= ST_IDLE;
        end
        default: begin
          ulpi_data_in_o <= 8'h00;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ulpi_tx_link.md
# ulpi_tx_link

Link-side ULPI transmit engine in the USB path of the Microwatt SoC. It converts the UTMI-style byte stream from the USB controller into the ULPI TX sequence on the external PHY pins: TX CMD, data bytes paced by NXT, then STP. Its pin outputs (`ulpi_data_in_o`, `ulpi_stp_o`) feed the external PHY directly. It owns the bus only while DIR is low and aborts cleanly when the PHY seizes the bus.

## Interface
Parameters:
- `TXCMD_EN`, default 1: 1 sends a ULPI TX CMD (0x40 | PID[3:0]) as the first byte; 0 sends the raw PID byte, for the simplified PHY stub.

Ports:
- `ulpi_clk60_i`  in  1  60 MHz ULPI clock; the single clock of this block.
- `ulpi_rst_i`  in  1  reset, asynchronous, active-high.
- `utmi_data_i`  in  8  TX byte; the first byte of a packet is the PID.
- `utmi_txvalid_i`  in  1  packet in progress; deasserts after the last byte.
- `utmi_txready_o`  out  1  byte on `utmi_data_i` is consumed this cycle.
- `ulpi_dir_i`  in  1  PHY owns the bus when high.
- `ulpi_nxt_i`  in  1  PHY has consumed the byte currently driven.
- `ulpi_data_in_o`  out  8  byte driven to the PHY.
- `ulpi_data_oe_o`  out  1  link drives the data bus.
- `ulpi_stp_o`  out  1  end-of-packet strobe.
- `tx_abort_o`  out  1  one-cycle pulse when a packet is aborted by DIR.
- `tx_busy_o`  out  1  state is not IDLE.

## Operation
- States: IDLE, CMD, DATA, STP, ABORT.
- `dir_q` is `ulpi_dir_i` registered once. The bus is "free" when `ulpi_dir_i` = 0 and `dir_q` = 0.
- IDLE: drive 0x00, STP low.
  - If `utmi_txvalid_i` and the bus is free: `utmi_txready_o` = 1 (PID consumed).
  - `ulpi_data_in_o` <= `TXCMD_EN` ? {4'h4, PID[3:0]} : PID.
  - Go to CMD.
- CMD and DATA: hold the driven byte until `ulpi_nxt_i` = 1. On NXT:
  - if `utmi_txvalid_i` = 1: `utmi_txready_o` = 1, load `utmi_data_i`, go to (or stay in) DATA;
  - else: go to STP and drive 0x00.
- STP: `ulpi_stp_o` = 1 and data 0x00 for exactly one cycle, then IDLE. `utmi_txready_o` = 0.
- DIR rises while in CMD or DATA (rising edge of `ulpi_dir_i`):
  - `tx_abort_o` pulses one cycle;
  - data output enable drops the same cycle (combinational from `ulpi_dir_i`);
  - go to ABORT.
- ABORT:
  - `utmi_txready_o` = `utmi_txvalid_i`, so upstream drains the rest of its packet;
  - go to IDLE when the bus is free and `utmi_txvalid_i` = 0;
  - no STP is issued.
- DIR rising in STP: STP completes; no abort.
- `ulpi_data_oe_o` = !`ulpi_dir_i` & !`dir_q`.
- `utmi_txready_o` is combinational from state, NXT, DIR and txvalid. It is never 1 while `ulpi_dir_i` = 1, except in ABORT.

## Timing
- Reset values: state IDLE, `ulpi_data_in_o` 0x00, `ulpi_stp_o` 0, `tx_abort_o` 0, `tx_busy_o` 0, `dir_q` 1. Because `dir_q` resets to 1, `ulpi_data_oe_o` is 0 for the first cycle after reset.
- Reset asserted mid-packet: immediate return to the reset values; no STP is generated.
- Latency from `utmi_txvalid_i` (bus free) to the TX CMD on the pins: 1 clock, since data and STP are registered.
- Each byte stays on the pins until the clock edge at which NXT is sampled high. The next byte appears on the following cycle.
- With NXT held high, throughput is 1 byte/clock. STP appears 1 clock after the last NXT.
- Idle gap: minimum 1 IDLE cycle after STP before a new TX CMD.
- DIR turnaround: after DIR falls, 1 cycle with output enable low; the earliest TX CMD is 2 clocks after DIR falls.

## Structure
- Shared package `usb_pkg`:
  - state enum;
  - `ULPI_TXCMD_PREFIX` = 4'h4;
  - PID constants OUT = 0xE1, DATA0 = 0xC3, DATA1 = 0x4B, ACK = 0xD2.
- Single module, no sub-modules. The byte hold register and the FSM live together.

## Test plan
- OUT token: PID 0xE1 plus bytes 0x01, 0x58, NXT always 1, `TXCMD_EN`=1 -> pins show 0x41, 0x01, 0x58, then STP with 0x00 for one cycle; `utmi_txready_o` high for 3 cycles.
- Same packet with `TXCMD_EN`=0, followed by DATA0 packet C3, AB -> pins show E1, 01, 58, STP, ≥1 idle cycle, C3, AB, STP.
- NXT stalls: NXT low for 3 cycles on byte 0x01 -> 0x01 held 4 cycles; `utmi_txready_o` low during the stall; byte order intact.
- DIR rises in DATA after byte 0x01 -> `tx_abort_o` pulses once, output enable low the same cycle, remaining bytes drained, no STP. After DIR falls, the next packet's TX CMD appears at DIR fall + 2 clocks.
- Reset asserted during DATA -> outputs 0x00/0 asynchronously; after release, a clean packet transmits normally.
- DIR high at the moment txvalid rises -> nothing driven and `utmi_txready_o` = 0 until the bus is free; then normal TX CMD.
